// File: rtl/tile_sequencer.sv
// tile_sequencer: tiling controller for a DIM x DIM systolic array computing C = A * B.
// Walks output tiles row-major, accumulates over all K tiles, drains DIM rows, clears.
//
//  state   | meaning
//  IDLE    | waiting for start
//  LOAD    | fetching DIM*DIM operand beats, holds while load_ready=0
//  COMPUTE | 3*DIM cycle wavefront through the array
//  WRITE   | draining result rows over the ready/valid port
//  CLEAR   | one-cycle accumulator clear, advance to the next output tile
//  DONE    | last tile cleared; done pulses on the following cycle
module tile_sequencer #(
    parameter int DIM    = 4,
    parameter int M_SIZE = 4,
    parameter int N_SIZE = 4,
    parameter int K_SIZE = 16,
    parameter int CNT_W  = 8,
    localparam int RW    = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               load_ready,
    input  logic               wr_ready,
    output logic               busy,
    output logic               done,
    output logic               rd_en,
    output logic [DIM-1:0]     in_valid_a,
    output logic [DIM-1:0]     in_valid_b,
    output logic [2*DIM-2:0]   skew_en,
    output logic               acc_clear,
    output logic               wr_valid,
    output logic [RW-1:0]      wr_row,
    output logic [CNT_W-1:0]   tile_m,
    output logic [CNT_W-1:0]   tile_n,
    output logic [CNT_W-1:0]   tile_k
);

    localparam int MT          = (M_SIZE + DIM - 1) / DIM;
    localparam int NT          = (N_SIZE + DIM - 1) / DIM;
    localparam int KT          = (K_SIZE + DIM - 1) / DIM;
    localparam int LOAD_BEATS  = DIM * DIM;
    localparam int COMP_CYCLES = 3 * DIM;
    localparam int CW          = $clog2(LOAD_BEATS + COMP_CYCLES);

    localparam logic [CW-1:0]    LOAD_LAST = CW'(LOAD_BEATS - 1);
    localparam logic [CW-1:0]    COMP_LAST = CW'(COMP_CYCLES - 1);
    localparam logic [CNT_W-1:0] MT_LAST   = CNT_W'(MT - 1);
    localparam logic [CNT_W-1:0] NT_LAST   = CNT_W'(NT - 1);
    localparam logic [CNT_W-1:0] KT_LAST   = CNT_W'(KT - 1);
    localparam logic [RW-1:0]    ROW_LAST  = RW'(DIM - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        COMPUTE = 3'd2,
        WRITE   = 3'd3,
        CLEAR   = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] tile_m_q, tile_m_d;
    logic [CNT_W-1:0] tile_n_q, tile_n_d;
    logic [CNT_W-1:0] tile_k_q, tile_k_d;
    logic [RW-1:0]    wr_row_q, wr_row_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             acc_clear_q, acc_clear_d;
    logic             wr_valid_q, wr_valid_d;
    logic [DIM-1:0]   in_valid_q, in_valid_d;
    logic [2*DIM-2:0] skew_en_q, skew_en_d;
    logic             beat_ok;

    // cnt_q is a down-counter: remaining beats in LOAD, remaining cycles in COMPUTE
    assign beat_ok = (state_q == LOAD) && load_ready && !abort;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tile_m_d = tile_m_q;
        tile_n_d = tile_n_q;
        tile_k_d = tile_k_q;
        wr_row_d = wr_row_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = LOAD;
                    cnt_d    = LOAD_LAST;
                    tile_m_d = '0;
                    tile_n_d = '0;
                    tile_k_d = '0;
                end
            end
            LOAD: begin
                if (load_ready) begin
                    if (cnt_q == '0) begin
                        state_d = COMPUTE;
                        cnt_d   = COMP_LAST;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            COMPUTE: begin
                if (cnt_q == '0) begin
                    if (tile_k_q < KT_LAST) begin
                        tile_k_d = tile_k_q + CNT_W'(1);
                        state_d  = LOAD;
                        cnt_d    = LOAD_LAST;
                    end else begin
                        tile_k_d = '0;
                        state_d  = WRITE;
                        wr_row_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WRITE: begin
                if (wr_ready) begin
                    if (wr_row_q == ROW_LAST) begin
                        state_d  = CLEAR;
                        wr_row_d = '0;
                    end else begin
                        wr_row_d = wr_row_q + RW'(1);
                    end
                end
            end
            CLEAR: begin
                if ((tile_m_q == MT_LAST) && (tile_n_q == NT_LAST)) begin
                    state_d  = DONE;
                    tile_m_d = '0;
                    tile_n_d = '0;
                end else begin
                    state_d = LOAD;
                    cnt_d   = LOAD_LAST;
                    if (tile_n_q == NT_LAST) begin
                        tile_n_d = '0;
                        tile_m_d = tile_m_q + CNT_W'(1);
                    end else begin
                        tile_n_d = tile_n_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d  = IDLE;
                tile_m_d = '0;
                tile_n_d = '0;
                tile_k_d = '0;
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d  = IDLE;
            cnt_d    = '0;
            tile_m_d = '0;
            tile_n_d = '0;
            tile_k_d = '0;
            wr_row_d = '0;
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    // The last LOAD beat's enable lands in the first COMPUTE cycle; both apply.
    always_comb begin
        int beat;
        int c_next;
        busy_d      = (state_d != IDLE);
        done_d      = (state_q == DONE) && !abort;
        acc_clear_d = (state_d == CLEAR) || abort;
        wr_valid_d  = (state_d == WRITE);
        in_valid_d  = '0;
        skew_en_d   = '0;
        beat        = LOAD_BEATS - 1 - int'(cnt_q);
        c_next      = COMP_CYCLES - 1 - int'(cnt_d);
        if (beat_ok) begin
            for (int r = 0; r < DIM; r++) begin
                if ((beat / DIM) == r) in_valid_d[DIM-1-r] = 1'b1;
            end
        end
        if (state_d == COMPUTE) begin
            for (int i = 0; i < DIM; i++) begin
                if (c_next >= i) in_valid_d[DIM-1-i] = 1'b1;
            end
            for (int j = 0; j < 2*DIM-1; j++) begin
                skew_en_d[j] = (c_next >= j + 1) && (c_next <= DIM + j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tile_m_q    <= '0;
            tile_n_q    <= '0;
            tile_k_q    <= '0;
            wr_row_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            acc_clear_q <= 1'b0;
            wr_valid_q  <= 1'b0;
            in_valid_q  <= '0;
            skew_en_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tile_m_q    <= tile_m_d;
            tile_n_q    <= tile_n_d;
            tile_k_q    <= tile_k_d;
            wr_row_q    <= wr_row_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            acc_clear_q <= acc_clear_d;
            wr_valid_q  <= wr_valid_d;
            in_valid_q  <= in_valid_d;
            skew_en_q   <= skew_en_d;
        end
    end

    // rd_en is the LOAD qualifier gated by load_ready so a stalled beat is never consumed
    assign rd_en      = beat_ok;
    assign busy       = busy_q;
    assign done       = done_q;
    assign in_valid_a = in_valid_q;
    assign in_valid_b = in_valid_q;
    assign skew_en    = skew_en_q;
    assign acc_clear  = acc_clear_q;
    assign wr_valid   = wr_valid_q;
    assign wr_row     = wr_row_q;
    assign tile_m     = tile_m_q;
    assign tile_n     = tile_n_q;
    assign tile_k     = tile_k_q;

endmodule

// File: tb/tb_tile_sequencer.sv
// Testbench for tile_sequencer: a procedural walk of the tiling schedule predicts every
// cycle's outputs under random ready/start stimulus, for two matrix configurations.
module tb_tile_sequencer;

    localparam int D  = 4;
    localparam int CW = 8;
    localparam int M0 = 4, N0 = 4, K0 = 16;
    localparam int M1 = 8, N1 = 8, K1 = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic start, abort, load_ready, wr_ready;
    logic sel;
    logic start_0, start_1;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc_cnt = 0;

    logic          busy_0, done_0, rd_0, clr_0, wv_0;
    logic [D-1:0]  iva_0, ivb_0;
    logic [2*D-2:0] sk_0;
    logic [1:0]    row_0;
    logic [CW-1:0] tm_0, tn_0, tk_0;
    logic          busy_1, done_1, rd_1, clr_1, wv_1;
    logic [D-1:0]  iva_1, ivb_1;
    logic [2*D-2:0] sk_1;
    logic [1:0]    row_1;
    logic [CW-1:0] tm_1, tn_1, tk_1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    assign start_0 = start & ~sel;
    assign start_1 = start & sel;

    tile_sequencer u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_0), .abort(abort),
        .load_ready(load_ready), .wr_ready(wr_ready), .busy(busy_0), .done(done_0),
        .rd_en(rd_0), .in_valid_a(iva_0), .in_valid_b(ivb_0), .skew_en(sk_0),
        .acc_clear(clr_0), .wr_valid(wv_0), .wr_row(row_0),
        .tile_m(tm_0), .tile_n(tn_0), .tile_k(tk_0)
    );

    tile_sequencer #(.DIM(D), .M_SIZE(M1), .N_SIZE(N1), .K_SIZE(K1), .CNT_W(CW)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_1), .abort(abort),
        .load_ready(load_ready), .wr_ready(wr_ready), .busy(busy_1), .done(done_1),
        .rd_en(rd_1), .in_valid_a(iva_1), .in_valid_b(ivb_1), .skew_en(sk_1),
        .acc_clear(clr_1), .wr_valid(wv_1), .wr_row(row_1),
        .tile_m(tm_1), .tile_n(tn_1), .tile_k(tk_1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_cnt);
        end
    endtask

    task automatic expect_cyc(input string ph, input logic e_busy, input logic e_done,
                              input logic e_rd, input logic [D-1:0] e_iv,
                              input logic [2*D-2:0] e_sk, input logic e_clr, input logic e_wv,
                              input logic [1:0] e_row, input int em, input int en, input int ek);
        chk({ph, ".busy"},       32'(sel ? busy_1 : busy_0), 32'(e_busy));
        chk({ph, ".done"},       32'(sel ? done_1 : done_0), 32'(e_done));
        chk({ph, ".rd_en"},      32'(sel ? rd_1 : rd_0),     32'(e_rd));
        chk({ph, ".in_valid_a"}, 32'(sel ? iva_1 : iva_0),   32'(e_iv));
        chk({ph, ".in_valid_b"}, 32'(sel ? ivb_1 : ivb_0),   32'(e_iv));
        chk({ph, ".skew_en"},    32'(sel ? sk_1 : sk_0),     32'(e_sk));
        chk({ph, ".acc_clear"},  32'(sel ? clr_1 : clr_0),   32'(e_clr));
        chk({ph, ".wr_valid"},   32'(sel ? wv_1 : wv_0),     32'(e_wv));
        chk({ph, ".wr_row"},     32'(sel ? row_1 : row_0),   32'(e_row));
        chk({ph, ".tile_m"},     32'(sel ? tm_1 : tm_0),     32'(em));
        chk({ph, ".tile_n"},     32'(sel ? tn_1 : tn_0),     32'(en));
        chk({ph, ".tile_k"},     32'(sel ? tk_1 : tk_0),     32'(ek));
    endtask

    function automatic logic [D-1:0] beat_iv(input int b);
        logic [D-1:0] v;
        v = '0;
        v[D-1-b/D] = 1'b1;
        return v;
    endfunction

    function automatic logic [D-1:0] comp_iv(input int c);
        logic [D-1:0] v;
        for (int i = 0; i < D; i++) v[D-1-i] = (c >= i);
        return v;
    endfunction

    function automatic logic [2*D-2:0] comp_skew(input int c);
        logic [2*D-2:0] v;
        for (int j = 0; j < 2*D-1; j++) v[j] = (j + 1 <= c) && (c <= D + j);
        return v;
    endfunction

    function automatic logic pick(input bit rnd, input int pct);
        if (!rnd) return 1'b1;
        return ($urandom_range(99) < pct);
    endfunction

    // One full matmul walked as nested tile loops. Optional directed events:
    // load stall at a beat, write stall at a row, abort at a COMPUTE step, reset mid-WRITE.
    task automatic run_seq(input bit rnd, input int ls_beat, input int ls_len,
                           input int ws_row, input int ws_len, input int abort_c,
                           input int rst_row);
        int mt, nt, kt, stalls, t0, tdone, b, r, lsl, wsl, ideal;
        logic lr, wr;
        logic [D-1:0] piv;
        mt = sel ? (M1 + D - 1) / D : (M0 + D - 1) / D;
        nt = sel ? (N1 + D - 1) / D : (N0 + D - 1) / D;
        kt = sel ? (K1 + D - 1) / D : (K0 + D - 1) / D;
        stalls = 0;
        lsl = ls_len;
        wsl = ws_len;

        start = 1'b1;
        abort = 1'b0;
        load_ready = pick(rnd, 50);
        wr_ready = pick(rnd, 50);
        @(negedge clk);
        expect_cyc("idle", 0, 0, 0, '0, '0, 0, 0, '0, 0, 0, 0);
        @(posedge clk); #1;
        t0 = cyc_cnt;
        start = 1'b0;

        for (int m = 0; m < mt; m++) begin
            for (int n = 0; n < nt; n++) begin
                for (int k = 0; k < kt; k++) begin
                    piv = '0;
                    b = 0;
                    while (b < D*D) begin
                        lr = pick(rnd, 75);
                        if (b == ls_beat && lsl > 0) begin
                            lr = 1'b0;
                            lsl--;
                        end
                        if (!lr) stalls++;
                        load_ready = lr;
                        wr_ready = 1'($urandom_range(1));
                        start = rnd ? 1'($urandom_range(1)) : 1'b0;
                        @(negedge clk);
                        expect_cyc("load", 1, 0, lr, piv, '0, 0, 0, '0, m, n, k);
                        @(posedge clk); #1;
                        if (lr) begin
                            piv = beat_iv(b);
                            b++;
                        end else begin
                            piv = '0;
                        end
                    end
                    for (int c = 0; c < 3*D; c++) begin
                        load_ready = 1'($urandom_range(1));
                        start = rnd ? 1'($urandom_range(1)) : 1'b0;
                        abort = (m == 0 && n == 0 && k == 0 && c == abort_c);
                        @(negedge clk);
                        expect_cyc("compute", 1, 0, 0, comp_iv(c) | ((c == 0) ? piv : '0),
                                   comp_skew(c), 0, 0, '0, m, n, k);
                        @(posedge clk); #1;
                        if (abort) begin
                            abort = 1'b0;
                            start = 1'b0;
                            @(negedge clk);
                            expect_cyc("abort", 0, 0, 0, '0, '0, 1, 0, '0, 0, 0, 0);
                            @(posedge clk); #1;
                            @(negedge clk);
                            expect_cyc("abort_after", 0, 0, 0, '0, '0, 0, 0, '0, 0, 0, 0);
                            @(posedge clk); #1;
                            return;
                        end
                    end
                end
                r = 0;
                while (r < D) begin
                    wr = pick(rnd, 70);
                    if (r == ws_row && wsl > 0) begin
                        wr = 1'b0;
                        wsl--;
                    end
                    if (!wr) stalls++;
                    wr_ready = wr;
                    load_ready = 1'($urandom_range(1));
                    start = rnd ? 1'($urandom_range(1)) : 1'b0;
                    @(negedge clk);
                    expect_cyc("write", 1, 0, 0, '0, '0, 0, 1, 2'(r), m, n, 0);
                    if (m == 0 && n == 0 && r == rst_row) begin
                        start = 1'b0;
                        #2 rst_n = 1'b0;
                        #1 expect_cyc("async_rst", 0, 0, 0, '0, '0, 0, 0, '0, 0, 0, 0);
                        @(posedge clk); #2 rst_n = 1'b1;
                        @(negedge clk);
                        expect_cyc("post_rst", 0, 0, 0, '0, '0, 0, 0, '0, 0, 0, 0);
                        @(posedge clk); #1;
                        return;
                    end
                    @(posedge clk); #1;
                    if (wr) r++;
                end
                start = rnd ? 1'($urandom_range(1)) : 1'b0;
                @(negedge clk);
                expect_cyc("clear", 1, 0, 0, '0, '0, 1, 0, '0, m, n, 0);
                @(posedge clk); #1;
            end
        end

        start = 1'b0;
        @(negedge clk);
        expect_cyc("done_state", 1, 0, 0, '0, '0, 0, 0, '0, 0, 0, 0);
        @(posedge clk); #1;
        tdone = cyc_cnt;
        @(negedge clk);
        expect_cyc("done", 0, 1, 0, '0, '0, 0, 0, '0, 0, 0, 0);
        ideal = mt * nt * (kt * (D*D + 3*D) + D + 1) + 1;
        chk("latency", 32'(tdone - t0), 32'(ideal + stalls));
        @(posedge clk); #1;
        @(negedge clk);
        expect_cyc("idle_after", 0, 0, 0, '0, '0, 0, 0, '0, 0, 0, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        load_ready = 1'b1;
        wr_ready = 1'b1;
        sel = 1'b0;
        #12;
        expect_cyc("reset", 0, 0, 0, '0, '0, 0, 0, '0, 0, 0, 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        run_seq(0, -1, 0, -1, 0, -1, -1);   // defaults, ready tied high
        run_seq(0,  7, 5, -1, 0, -1, -1);   // load stall at beat 7
        run_seq(0, -1, 0,  2, 3, -1, -1);   // write backpressure on row 2
        sel = 1'b1;
        run_seq(0, -1, 0, -1, 0, -1, -1);   // 2x2 output tiles, one K tile
        run_seq(1, -1, 0, -1, 0, -1, -1);
        sel = 1'b0;
        run_seq(0, -1, 0, -1, 0,  5, -1);   // abort at c=5
        run_seq(0, -1, 0, -1, 0, -1, -1);   // full run after abort
        run_seq(1, -1, 0, -1, 0, -1,  2);   // reset mid-WRITE
        for (int i = 0; i < 3; i++) begin
            sel = 1'(i % 2);
            run_seq(1, -1, 0, -1, 0, -1, -1);
        end
        sel = 1'b0;
        run_seq(1, 3, 4, 1, 2, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
